capture_window: RTL and testbench

- Downstream consumer of the delayed trigger stage. Once armed, it waits for the delayed trigger level, then writes exactly CAPTURE_LEN consecutive valid ADC samples into a sample RAM through a simple write port.
- Raises a sticky done flag when the window is full, so the readout logic (UART/VGA dump) can fetch the buffer.
- Re-arming clears done and starts a new acquisition.

---
 rtl/capture_window_pkg.sv | 24 ++
 rtl/capture_window_if.sv | 36 +++
 rtl/capture_window.sv | 113 +++++++++++
 tb/tb_capture_window.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_window_pkg.sv
// Shared constants for the capture path: FSM state encoding and default bus widths.
// The sample RAM and the readout blocks size their ports from the same defaults,
// so changing a width here keeps the whole acquisition chain consistent.
package capture_pkg;

  // Default widths shared by the capture block, the sample RAM and the readout logic.
  localparam int DATA_WIDTH_DEF  = 8;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int CAPTURE_LEN_DEF = 200;

  // Acquisition FSM encoding.
  typedef logic [1:0] cw_state_t;

  localparam cw_state_t ST_IDLE    = 2'd0;
  localparam cw_state_t ST_ARMED   = 2'd1;
  localparam cw_state_t ST_CAPTURE = 2'd2;
  localparam cw_state_t ST_DONE    = 2'd3;

  // True when a window length fits the RAM address space (1..2^addr_width).
  function automatic bit capture_len_ok(input int len, input int addr_width);
    return (len >= 1) && (len <= (1 << addr_width));
  endfunction

endpackage

// File: rtl/capture_window_if.sv
// Sample input and RAM write port of the capture block bundled as one interface.
// master: the capture block (consumes samples, drives the RAM write port).
// slave: the surrounding top level (ADC front end plus the sample RAM).
interface capture_window_if
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  // ADC side: one sample qualified by a valid strobe.
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;

  // RAM write port, all registered by the capture block.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    input  sample_valid,
    input  sample_data,
    output mem_we,
    output mem_addr,
    output mem_data
  );

  modport slave (
    output sample_valid,
    output sample_data,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

endinterface

// File: rtl/capture_window.sv
// Purpose: after arm, wait for the delayed trigger level, then write CAPTURE_LEN valid samples to RAM.
// Latency: one cycle from an accepted sample to its registered RAM write; done rises with the last write.
// Backpressure: none; samples are taken whenever sample_valid is high in CAPTURE, the RAM never stalls.
module capture_window
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int CAPTURE_LEN = CAPTURE_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger_in,
  capture_window_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sample_count
);

  // The counter carries one extra bit so a window of exactly 2^ADDR_WIDTH samples
  // can report its full length without wrapping.
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAPTURE_LEN - 1);

  // Reject window lengths the RAM cannot hold.
  if (!capture_len_ok(CAPTURE_LEN, ADDR_WIDTH)) begin : g_bad_capture_len
    $error("capture_window: CAPTURE_LEN must lie in 1..2**ADDR_WIDTH");
  end

  cw_state_t state;

  // Acquisition FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      // A write strobe lasts exactly one cycle; address and data simply hold.
      bus.mem_we <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state        <= ST_ARMED;
            busy         <= 1'b1;
            done         <= 1'b0;
            sample_count <= '0;
          end
        end

        // Waiting for the trigger level. A sample arriving together with the
        // trigger is deliberately dropped: the window starts one cycle later.
        // A repeated arm here changes nothing.
        ST_ARMED: begin
          if (trigger_in) begin
            state <= ST_CAPTURE;
          end
        end

        // Trigger and arm are both ignored while filling the window.
        ST_CAPTURE: begin
          if (bus.sample_valid) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= sample_count[ADDR_WIDTH-1:0];
            bus.mem_data <= bus.sample_data;
            sample_count <= sample_count + CNT_W'(1);
            // Final write: done and the last strobe appear on the same edge.
            if (sample_count == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        // Buffer is full and stays readable until re-armed. With a still-high
        // trigger the new window starts straight after ARMED, which is intended.
        ST_DONE: begin
          if (arm) begin
            state        <= ST_ARMED;
            busy         <= 1'b1;
            done         <= 1'b0;
            sample_count <= '0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // busy and done describe mutually exclusive phases of one acquisition.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (reset) !(busy && done));

  // Writes happen only while filling, or on the final write that enters DONE.
  a_we_in_window: assert property (@(posedge clk) disable iff (reset)
    bus.mem_we |-> (state == ST_CAPTURE || state == ST_DONE));

  // The count never exceeds the window length.
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    sample_count <= CNT_W'(CAPTURE_LEN));

endmodule

// File: tb/tb_capture_window.sv
module tb_capture_window;

  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int LEN = 8;   // equals 2**AW: exercises the full-address-range boundary

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          trigger_in = 1'b0;
  logic          busy;
  logic          done;
  logic [AW:0]   sample_count;

  int checks = 0;
  int errors = 0;

  capture_window_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  capture_window #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CAPTURE_LEN(LEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .trigger_in  (trigger_in),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting for trigger, 2 filling, 3 buffer full.
  int        m_phase = 0;
  int        m_fill  = 0;
  bit        m_we    = 0;
  int        m_addr  = 0;
  int        m_data  = 0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_phase = 0; m_fill = 0; m_we = 0; m_addr = 0; m_data = 0;
      end else begin
        m_we = 0;
        case (m_phase)
          0, 3: if (arm) begin m_phase = 1; m_fill = 0; end
          1:    if (trigger_in) m_phase = 2;
          2:    if (bus.sample_valid) begin
                  m_we   = 1;
                  m_addr = m_fill % (1 << AW);
                  m_data = int'(bus.sample_data);
                  m_fill = m_fill + 1;
                  if (m_fill == LEN) m_phase = 3;
                end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Every-cycle compare plus a log of the writes the DUT issues.
  int wq[$];
  initial begin
    forever begin
      @(negedge clk);
      cmp("mem_we",       32'(bus.mem_we),   32'(m_we));
      cmp("mem_addr",     32'(bus.mem_addr), 32'(m_addr));
      cmp("mem_data",     32'(bus.mem_data), 32'(m_data));
      cmp("busy",         32'(busy),         32'(m_phase == 1 || m_phase == 2));
      cmp("done",         32'(done),         32'(m_phase == 3));
      cmp("sample_count", 32'(sample_count), 32'(m_fill));
      if (bus.mem_we === 1'b1) wq.push_back((int'(bus.mem_addr) << 8) | int'(bus.mem_data));
    end
  end

  // Inputs change 1 ns after the falling edge, well clear of both edges.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic check_writes(input string nm, input int exp_data[$]);
    cmp({nm, "_count"}, 32'(wq.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < wq.size(); i++) begin
      cmp({nm, "_addr"}, 32'(wq[i] >> 8), 32'(i));
      cmp({nm, "_data"}, 32'(wq[i] & 'hFF), 32'(exp_data[i]));
    end
  endtask

  int exp_q[$];
  logic [15:0] gap_pat;

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;

    // Reset, then a trigger without arm must do nothing.
    repeat (3) tick();
    reset = 1'b0;
    trigger_in = 1'b1;
    repeat (5) tick();
    cmp("idle_we",    32'(bus.mem_we),   0);
    cmp("idle_busy",  32'(busy),         0);
    cmp("idle_done",  32'(done),         0);
    cmp("idle_count", 32'(sample_count), 0);
    cmp("idle_nowr",  32'(wq.size()),    0);
    trigger_in = 1'b0;

    // Basic capture: trigger two cycles after arm, data increments every cycle.
    wq.delete();
    arm_pulse();
    tick();
    trigger_in = 1'b1;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.sample_data = 8'(8'h10 + i);
      tick();
      if (i == 8) begin
        cmp("basic_done_on_last", 32'(done), 1);
        cmp("basic_busy_on_last", 32'(busy), 0);
        cmp("basic_we_on_last",   32'(bus.mem_we), 1);
      end
    end
    exp_q = '{'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 'h18};
    check_writes("basic", exp_q);
    cmp("basic_final_count", 32'(sample_count), LEN);
    cmp("basic_final_done",  32'(done), 1);
    trigger_in = 1'b0;
    bus.sample_valid = 1'b0;

    // Gapped valid; trigger drops and arm pulses mid-capture without effect.
    wq.delete();
    arm_pulse();
    trigger_in = 1'b1;
    tick();
    trigger_in = 1'b0;
    gap_pat = 16'b1111_0110_1110_1001;   // bit i = valid in cycle i
    for (int i = 0; i < 16; i++) begin
      bus.sample_valid = gap_pat[i];
      bus.sample_data  = 8'(8'hA0 + i);
      arm = (i == 4);
      tick();
    end
    arm = 1'b0;
    bus.sample_valid = 1'b0;
    exp_q = '{'hA0, 'hA3, 'hA5, 'hA6, 'hA7, 'hA9, 'hAA, 'hAC};
    check_writes("gapped", exp_q);
    cmp("gapped_done", 32'(done), 1);

    // Trigger and valid rising together: 0x55 must be dropped.
    wq.delete();
    arm_pulse();
    tick();
    trigger_in = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_data = 8'h55;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.sample_data = 8'(8'h66 + i);
      tick();
    end
    exp_q = '{'h66, 'h67, 'h68, 'h69, 'h6A, 'h6B, 'h6C, 'h6D};
    check_writes("trigvalid", exp_q);
    trigger_in = 1'b0;
    bus.sample_valid = 1'b0;

    // Asynchronous reset after three writes, between clock edges.
    wq.delete();
    arm_pulse();
    trigger_in = 1'b1;
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.sample_data = 8'(8'h30 + i);
      tick();
    end
    cmp("midrst_pre_count", 32'(sample_count), 3);
    #2 reset = 1'b1;
    #1;
    cmp("midrst_we",    32'(bus.mem_we),   0);
    cmp("midrst_addr",  32'(bus.mem_addr), 0);
    cmp("midrst_data",  32'(bus.mem_data), 0);
    cmp("midrst_busy",  32'(busy),         0);
    cmp("midrst_count", 32'(sample_count), 0);
    tick();
    reset = 1'b0;
    trigger_in = 1'b0;
    tick();
    cmp("midrst_idle_busy", 32'(busy), 0);
    wq.delete();
    arm_pulse();
    trigger_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.sample_data = 8'(8'h40 + i);
      tick();
    end
    exp_q = '{'h41, 'h42, 'h43, 'h44, 'h45, 'h46, 'h47, 'h48};
    check_writes("postrst", exp_q);

    // Re-arm from DONE with the trigger still high.
    wq.delete();
    bus.sample_data = 8'hE0;
    arm_pulse();
    cmp("rearm_done_clr", 32'(done), 0);
    cmp("rearm_busy",     32'(busy), 1);
    cmp("rearm_count",    32'(sample_count), 0);
    cmp("rearm_no_we",    32'(bus.mem_we), 0);
    bus.sample_data = 8'hE1;              // trigger-detection cycle: dropped
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.sample_data = 8'(8'hF0 + i);
      arm = (i == 3);                     // ignored while filling
      tick();
    end
    arm = 1'b0;
    exp_q = '{'hF0, 'hF1, 'hF2, 'hF3, 'hF4, 'hF5, 'hF6, 'hF7};
    check_writes("rearm", exp_q);
    cmp("rearm_final_done", 32'(done), 1);

    // Random traffic, including occasional asynchronous resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      arm              = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) trigger_in = ~trigger_in;
      bus.sample_valid = ($urandom_range(0, 9) < 7);
      bus.sample_data  = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    arm = 1'b0;
    bus.sample_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
